serial_sum_collector: RTL

Downstream stage of the bit-serial adder path. Takes one sum bit per cycle, LSB first, plus the final carry. Assembles them into a parallel (WIDTH+1)-bit result and presents it on a valid/ready handshake to the consumer, so the parallel result is registered and explicitly framed.

---
 rtl/serial_sum_collector_if.sv | 27 ++
 rtl/serial_sum_collector.sv | 78 +++++++
 2 files changed

// File: rtl/serial_sum_collector_if.sv
// serial_sum_collector_if: serial bit stream in, framed parallel result out (ovr with SERIAL_COLLECT_OVR_EN)
interface serial_sum_collector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic             bit_valid;
  logic             sum_bit;
  logic             carry_bit;
  logic             res_ready;
  logic [WIDTH:0]   result;
  logic             res_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SERIAL_COLLECT_OVR_EN
  logic             ovr;
  modport master (output start, bit_valid, sum_bit, carry_bit, res_ready,
                  input result, res_valid, busy, bit_cnt, ovr);
  modport slave  (input start, bit_valid, sum_bit, carry_bit, res_ready,
                  output result, res_valid, busy, bit_cnt, ovr);
`else
  modport master (output start, bit_valid, sum_bit, carry_bit, res_ready,
                  input result, res_valid, busy, bit_cnt);
  modport slave  (input start, bit_valid, sum_bit, carry_bit, res_ready,
                  output result, res_valid, busy, bit_cnt);
`endif
endinterface

// File: rtl/serial_sum_collector.sv
// serial_sum_collector: assembles LSB-first sum bits plus carry into a valid/ready framed word
// Optional overrun flag (ovr) enabled by SERIAL_COLLECT_OVR_EN.
module serial_sum_collector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  serial_sum_collector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] shreg, nxt, sel;
  logic [WIDTH:0]   result;
  logic [CNT_W-1:0] cnt;
  logic             res_valid, busy, last, hs, start_ok;
  always_comb begin
    sel      = WIDTH'(1) << cnt;
    nxt      = bus.sum_bit ? (shreg | sel) : (shreg & ~sel);
    last     = cnt == CNT_W'(WIDTH - 1);
    hs       = state == HOLD && bus.res_ready;
    start_ok = bus.start && (state == IDLE || hs);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.start) begin
            state <= COLLECT;
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        COLLECT:
          if (bus.bit_valid) begin
            shreg <= nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
              result    <= {bus.carry_bit, nxt};
              res_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= HOLD;
            end
          end
        HOLD:
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            busy      <= bus.start;
            state     <= bus.start ? COLLECT : IDLE;
            if (bus.start) begin
              shreg <= '0;
              cnt   <= '0;
            end
          end
        default: state <= IDLE;
      endcase
    end
`ifdef SERIAL_COLLECT_OVR_EN
  logic ovr;
  // a new word starts with a clean flag even if a stray bit arrives alongside start
  always_ff @(posedge clk or posedge rst)
    if (rst) ovr <= 1'b0;
    else if (start_ok) ovr <= 1'b0;
    else if (bus.bit_valid && state != COLLECT) ovr <= 1'b1;
  assign bus.ovr = ovr;
`endif
  assign bus.result    = result;
  assign bus.res_valid = res_valid;
  assign bus.busy      = busy;
  assign bus.bit_cnt   = cnt;
endmodule
